// File: rtl/parc_mem_port_arb.sv
// ---------------------------------------------------------------------------
// parc_mem_port_arb
//
// Two-to-one memory port arbiter sitting directly below the PARCv2 core.
// The imem (port 0) and dmem (port 1) request streams are merged onto one
// memory request port with round-robin priority. Memory answers in issue
// order, so a small FIFO of port IDs is enough to route each response back
// to the port that issued the matching request.
//
// Optional feature: define PARC_MEM_ARB_STATS_EN to build the grant and
// conflict counters. When it is undefined, the stat_* outputs remain on the
// port list but are tied to zero.
//
// Message layouts follow the vc mem formats:
//   request  = {type, addr, len, data}
//   response = {type, len, data}
// The arbiter never looks inside a message. It only passes messages through.
// ---------------------------------------------------------------------------
module parc_mem_port_arb #(
    parameter  int p_max_out = 4,
    parameter  int p_addr_sz = 32,
    parameter  int p_data_sz = 32,
    localparam int c_len_sz  = $clog2(p_data_sz / 8),
    localparam int c_req_sz  = 1 + p_addr_sz + c_len_sz + p_data_sz,
    localparam int c_resp_sz = 1 + c_len_sz + p_data_sz
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [c_req_sz-1:0]  ireq_msg,
    input  logic                 ireq_val,
    output logic                 ireq_rdy,
    output logic [c_resp_sz-1:0] iresp_msg,
    output logic                 iresp_val,

    input  logic [c_req_sz-1:0]  dreq_msg,
    input  logic                 dreq_val,
    output logic                 dreq_rdy,
    output logic [c_resp_sz-1:0] dresp_msg,
    output logic                 dresp_val,

    output logic [c_req_sz-1:0]  memreq_msg,
    output logic                 memreq_val,
    input  logic                 memreq_rdy,
    input  logic [c_resp_sz-1:0] memresp_msg,
    input  logic                 memresp_val,

    output logic                 resp_err,

    output logic [31:0]          stat_igrant,
    output logic [31:0]          stat_dgrant,
    output logic [31:0]          stat_conflict
);

    // Port identifiers. They are used both as the priority pointer value and
    // as the entries stored in the ID FIFO.
    localparam logic [0:0] PORT_I = 1'b0;
    localparam logic [0:0] PORT_D = 1'b1;

    localparam int c_ptr_sz = $clog2(p_max_out);

    localparam logic [c_ptr_sz:0]   c_full_cnt = (c_ptr_sz + 1)'(p_max_out);
    localparam logic [c_ptr_sz:0]   c_cnt_one  = (c_ptr_sz + 1)'(1);
    localparam logic [c_ptr_sz-1:0] c_ptr_one  = c_ptr_sz'(1);

    // ID FIFO state. Because p_max_out is a power of two, the read and write
    // pointers wrap on their own. count tells full apart from empty.
    logic [0:0]          id_mem [p_max_out];
    logic [c_ptr_sz-1:0] wr_ptr;
    logic [c_ptr_sz-1:0] rd_ptr;
    logic [c_ptr_sz:0]   count;

    // Round-robin pointer: the port that wins a tie.
    logic [0:0] prio;

    logic       full;
    logic       empty;
    logic [0:0] grant;
    logic       fire;
    logic       pop;
    logic [0:0] head_id;

    assign full    = (count == c_full_cnt);
    assign empty   = (count == '0);
    assign head_id = id_mem[rd_ptr];

    // Choose the granted port. A lone requester always wins. When both ports
    // request, the priority pointer decides. When neither requests, port 0 is
    // selected, but memreq_val stays low.
    always_comb begin
        grant = PORT_I;
        if (ireq_val && dreq_val) begin
            grant = prio;
        end else if (dreq_val) begin
            grant = PORT_D;
        end
    end

    // Request side. Issue is blocked while the FIFO is full, even if a pop
    // frees a slot in the same cycle. This keeps count off any path from
    // memresp_val to memreq_val.
    always_comb begin
        memreq_val = (ireq_val || dreq_val) && !full;
        memreq_msg = (grant == PORT_D) ? dreq_msg : ireq_msg;
        fire       = memreq_val && memreq_rdy;
        ireq_rdy   = (grant == PORT_I) && memreq_rdy && !full && ireq_val;
        dreq_rdy   = (grant == PORT_D) && memreq_rdy && !full && dreq_val;
    end

    // Response side. The head ID steers the response to its port. A response
    // that arrives with nothing in flight is dropped, and resp_err records it.
    always_comb begin
        pop       = memresp_val && !empty;
        iresp_val = pop && (head_id == PORT_I);
        dresp_val = pop && (head_id == PORT_D);
        iresp_msg = memresp_msg;
        dresp_msg = memresp_msg;
    end

    // Write the granted port ID into the FIFO slot at the write pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_max_out; i++) begin
                id_mem[i] <= PORT_I;
            end
        end else if (fire) begin
            id_mem[wr_ptr] <= grant;
        end
    end

    // Update the FIFO pointers and the occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fire) begin
                wr_ptr <= wr_ptr + c_ptr_one;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + c_ptr_one;
            end
            case ({fire, pop})
                2'b10:   count <= count + c_cnt_one;
                2'b01:   count <= count - c_cnt_one;
                default: count <= count;
            endcase
        end
    end

    // Round-robin: after each issue, the winner becomes the low-priority port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio <= PORT_I;
        end else if (fire) begin
            prio <= (grant == PORT_I) ? PORT_D : PORT_I;
        end
    end

    // Sticky error flag for a response with no matching request. Only reset
    // clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_err <= 1'b0;
        end else if (memresp_val && empty) begin
            resp_err <= 1'b1;
        end
    end

`ifdef PARC_MEM_ARB_STATS_EN

    logic [31:0] igrant_cnt;
    logic [31:0] dgrant_cnt;
    logic [31:0] conflict_cnt;

    // Count issues per port, plus the cycles where both ports want the
    // memory and the FIFO has room. The counters wrap at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            igrant_cnt   <= 32'd0;
            dgrant_cnt   <= 32'd0;
            conflict_cnt <= 32'd0;
        end else begin
            if (fire && (grant == PORT_I)) begin
                igrant_cnt <= igrant_cnt + 32'd1;
            end
            if (fire && (grant == PORT_D)) begin
                dgrant_cnt <= dgrant_cnt + 32'd1;
            end
            if (ireq_val && dreq_val && !full) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end

    assign stat_igrant   = igrant_cnt;
    assign stat_dgrant   = dgrant_cnt;
    assign stat_conflict = conflict_cnt;

`else

    assign stat_igrant   = 32'd0;
    assign stat_dgrant   = 32'd0;
    assign stat_conflict = 32'd0;

`endif

endmodule
